// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer master with command/response handshakes.
// Optional macro WB_INITIATOR_STATS_EN adds saturating ok/error transfer counters.
`default_nettype none

module wb_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
`ifdef WB_INITIATOR_STATS_EN
    ,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        ok_evt, err_evt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        ok_evt      = 1'b0;
        err_evt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // An ack on the final timeout edge takes priority over the abort.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    ok_evt      = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    err_evt     = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

`ifdef WB_INITIATOR_STATS_EN
    logic [15:0] stat_ok_q, stat_err_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            stat_ok_q  <= 16'h0;
            stat_err_q <= 16'h0;
        end else begin
            if (ok_evt && stat_ok_q != 16'hFFFF) begin
                stat_ok_q <= stat_ok_q + 16'd1;
            end
            if (err_evt && stat_err_q != 16'hFFFF) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_err = stat_err_q;
`else
    logic unused_evt;
    assign unused_evt = ok_evt ^ err_evt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed vector table plus hand-written reset/ack corner sequences.
`default_nettype none

module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0;
`ifdef WB_INITIATOR_STATS_EN
    logic [15:0] stat_ok, stat_err;
`endif

    int checks = 0;
    int failures = 0;
    int exp_ok = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT(16), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack)
`ifdef WB_INITIATOR_STATS_EN
        ,
        .stat_ok  (stat_ok),
        .stat_err (stat_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          ack_at;    // cyc cycle in which the slave acks; 0 = never
        int          hold;      // cycles rsp_ready stays low
        int          exp_cyc;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        logic [31:0] d0;
        cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.wdat; cmd_sel = v.sel;
        dat_i = v.rdata;
        cmd_valid = 1'b1;
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (cyc && n < 300) begin
            n++;
            if (n == 1) begin
                chk({tag, "_adr"}, adr, v.adr);
                chk({tag, "_dat_o"}, dat_o, v.wdat);
                chk({tag, "_we_sel"}, {27'h0, we, sel}, {27'h0, v.we, v.sel});
                chk({tag, "_stb"}, 32'(stb), 32'd1);
            end
            if (cmd_ready || rsp_valid) chk({tag, "_bus_flags"}, {30'h0, cmd_ready, rsp_valid}, 32'h0);
            ack = (n == v.ack_at);
            @(posedge clk); #1;
            ack = 1'b0;
        end
        chk({tag, "_cyc_cycles"}, 32'(n), 32'(v.exp_cyc));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_dat"}, rsp_dat, v.exp_dat);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, "_stb_low"}, {30'h0, stb, we}, 32'h0);
        if (v.exp_err) exp_err++; else exp_ok++;
        d0 = rsp_dat;
        for (int i = 0; i < v.hold; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'h0, rsp_valid}, 32'd1);
            chk({tag, "_hold_dat"}, rsp_dat, d0);
            chk({tag, "_hold_noacc"}, {30'h0, cmd_ready, cyc}, 32'h0);
        end
        cmd_valid = 1'b0;
        chk({tag, "_ready_resp"}, 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_adr_kept"}, adr, v.adr);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h3000000C, 32'h00000001, 4'hF, 32'hFFFFFFFF, 1,  0, 1,  32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h30000004, 32'h0,        4'hF, 32'h4669626F, 4,  0, 4,  32'h4669626F, 1'b0};
        vecs[2] = '{1'b0, 32'h30000010, 32'h0,        4'hF, 32'hDEADBEEF, 0,  2, 16, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 32'h30000008, 32'h0,        4'hF, 32'h12345678, 2,  5, 2,  32'h12345678, 1'b0};
        vecs[4] = '{1'b1, 32'h30000000, 32'h0000A5A5, 4'h3, 32'h11111111, 16, 1, 16, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 32'h3000000C, 32'h0,        4'h1, 32'h00C0FFEE, 16, 0, 16, 32'h00C0FFEE, 1'b0};

        #12;
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_bus", {27'h0, cyc, stb, we, rsp_valid, rsp_err}, 32'h0);
        chk("reset_adr", adr, 32'h0);
        chk("reset_rsp_dat", rsp_dat, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ack outside BUS must not start or complete anything
        ack = 1'b1;
        repeat (2) @(posedge clk);
        #1; ack = 1'b0;
        chk("idle_ack_ignored", {30'h0, cyc, rsp_valid}, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // asynchronous reset two cycles into a read
        cmd_we = 1'b0; cmd_adr = 32'h30000004; cmd_sel = 4'hF; dat_i = 32'h4669626F;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("rst_pre_cyc", 32'(cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {29'h0, cyc, stb, rsp_valid}, 32'h0);
        chk("rst_async_ready", 32'(cmd_ready), 32'd1);
        exp_ok = 0; exp_err = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_ready", {30'h0, cmd_ready, rsp_valid}, 32'h2);
        run_vec(vecs[1], "post_rst");
        run_vec(vecs[0], "post_rst_w");
        run_vec(vecs[2], "post_rst_to");

`ifdef WB_INITIATOR_STATS_EN
        chk("stat_ok", 32'(stat_ok), 32'(exp_ok));
        chk("stat_err", 32'(stat_err), 32'(exp_err));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
